// File: rtl/mdu_hilo_if.sv
// Request/response bundle between the E-stage control and the multiply/divide HI/LO unit.
// The master side issues requests and reads HI/LO; the slave side is the unit itself.
interface mdu_hilo_if;
    logic        start;
    logic [2:0]  md_op;
    logic [31:0] A;
    logic [31:0] B;
    logic        busy;
    logic        done;
    logic [31:0] HI;
    logic [31:0] LO;

    modport master (
        output start, md_op, A, B,
        input  busy, done, HI, LO
    );

    modport slave (
        input  start, md_op, A, B,
        output busy, done, HI, LO
    );
endinterface

// File: rtl/mdu_hilo.sv
// Multi-cycle multiply/divide unit with HI/LO registers for the E stage.
// A request is latched, busy is held for a fixed latency, then HI/LO commit together.
module mdu_hilo #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    mdu_hilo_if.slave   md
);

    localparam int CNT_MAX = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t             state_r;
    logic [CNT_W-1:0]   cnt_r;
    logic [2:0]         op_r;
    logic [31:0]        a_r;
    logic [31:0]        b_r;
    logic [31:0]        hi_r;
    logic [31:0]        lo_r;
    logic               busy_r;
    logic               done_r;
    logic [63:0]        res_s;

    // 64-bit product; the signed form sign-extends both operands first.
    function automatic logic [63:0] mul64(input logic [31:0] a, input logic [31:0] b,
                                          input logic is_signed);
        logic [63:0] ax;
        logic [63:0] bx;
        ax = is_signed ? {{32{a[31]}}, a} : {32'd0, a};
        bx = is_signed ? {{32{b[31]}}, b} : {32'd0, b};
        return ax * bx;
    endfunction

    // Returns {remainder, quotient}. Signed division works on magnitudes so that
    // 0x80000000 / -1 falls out as quotient 0x80000000, remainder 0.
    function automatic logic [63:0] div64(input logic [31:0] a, input logic [31:0] b,
                                          input logic is_signed);
        logic        a_neg;
        logic        b_neg;
        logic [31:0] a_mag;
        logic [31:0] b_mag;
        logic [31:0] q_mag;
        logic [31:0] r_mag;
        logic [31:0] q;
        logic [31:0] r;
        a_neg = is_signed & a[31];
        b_neg = is_signed & b[31];
        a_mag = a_neg ? (32'd0 - a) : a;
        b_mag = b_neg ? (32'd0 - b) : b;
        q_mag = a_mag / b_mag;
        r_mag = a_mag % b_mag;
        q     = (a_neg ^ b_neg) ? (32'd0 - q_mag) : q_mag;
        r     = a_neg ? (32'd0 - r_mag) : r_mag;
        return {r, q};
    endfunction

    // Result of the latched operation; divide by zero keeps the current HI/LO.
    always_comb begin
        res_s = {hi_r, lo_r};
        case (op_r)
            3'd0: res_s = mul64(a_r, b_r, 1'b1);
            3'd1: res_s = mul64(a_r, b_r, 1'b0);
            3'd2: begin
                if (b_r != 32'd0) begin
                    res_s = div64(a_r, b_r, 1'b1);
                end else begin
                    res_s = {hi_r, lo_r};
                end
            end
            3'd3: begin
                if (b_r != 32'd0) begin
                    res_s = div64(a_r, b_r, 1'b0);
                end else begin
                    res_s = {hi_r, lo_r};
                end
            end
            default: res_s = {hi_r, lo_r};
        endcase
    end

    // Control FSM, operand latch, latency counter and HI/LO registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= ST_IDLE;
            cnt_r   <= {CNT_W{1'b0}};
            op_r    <= 3'd0;
            a_r     <= 32'd0;
            b_r     <= 32'd0;
            hi_r    <= 32'd0;
            lo_r    <= 32'd0;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            done_r <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (md.start && (md.md_op <= 3'd3)) begin
                        op_r    <= md.md_op;
                        a_r     <= md.A;
                        b_r     <= md.B;
                        cnt_r   <= md.md_op[1] ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
                        busy_r  <= 1'b1;
                        state_r <= ST_RUN;
                    end else if (md.md_op == 3'd4) begin
                        hi_r <= md.A;
                    end else if (md.md_op == 3'd5) begin
                        lo_r <= md.A;
                    end else begin
                        busy_r <= 1'b0;
                    end
                end
                ST_RUN: begin
                    // Requests arriving here are dropped; only the counter advances.
                    if (cnt_r == CNT_W'(1)) begin
                        {hi_r, lo_r} <= res_s;
                        done_r       <= 1'b1;
                        busy_r       <= 1'b0;
                        cnt_r        <= {CNT_W{1'b0}};
                        state_r      <= ST_IDLE;
                    end else begin
                        cnt_r <= cnt_r - CNT_W'(1);
                    end
                end
                default: begin
                    busy_r  <= 1'b0;
                    cnt_r   <= {CNT_W{1'b0}};
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    assign md.busy = busy_r;
    assign md.done = done_r;
    assign md.HI   = hi_r;
    assign md.LO   = lo_r;

endmodule

// File: tb/tb_mdu_hilo.sv
// Self-checking bench for mdu_hilo: directed cases plus random operations checked
// against an arithmetic reference model of HI/LO.
module tb_mdu_hilo;
    localparam int MC = 5;
    localparam int DC = 10;

    logic clk = 1'b0;
    logic reset;
    int   errors = 0;
    int   checks = 0;
    logic [31:0] m_hi = 32'd0;
    logic [31:0] m_lo = 32'd0;

    always #5 clk = ~clk;

    mdu_hilo_if ifc();

    mdu_hilo #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
        .clk   (clk),
        .reset (reset),
        .md    (ifc)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference: what HI/LO must hold after the given operation.
    task automatic model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        int sa;
        int sb;
        longint sp;
        longint unsigned up;
        sa = a;
        sb = b;
        case (op)
            3'd0: begin
                sp = longint'(sa) * longint'(sb);
                m_hi = sp[63:32];
                m_lo = sp[31:0];
            end
            3'd1: begin
                up = {32'd0, a};
                up = up * {32'd0, b};
                m_hi = up[63:32];
                m_lo = up[31:0];
            end
            3'd2: begin
                if (b != 32'd0) begin
                    if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
                        m_lo = 32'h8000_0000;
                        m_hi = 32'd0;
                    end else begin
                        m_lo = sa / sb;
                        m_hi = sa % sb;
                    end
                end
            end
            3'd3: begin
                if (b != 32'd0) begin
                    m_lo = a / b;
                    m_hi = a % b;
                end
            end
            3'd4: m_hi = a;
            3'd5: m_lo = a;
            default: ;
        endcase
    endtask

    task automatic idle_inputs();
        ifc.start = 1'b0;
        ifc.md_op = 3'd7;
    endtask

    // Launch a multi-cycle op, measure busy, check commit and done pulse.
    task automatic run_md(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                          input bit interfere);
        int n;
        int exp_n;
        exp_n = op[1] ? DC : MC;
        @(negedge clk);
        ifc.start = 1'b1; ifc.md_op = op; ifc.A = a; ifc.B = b;
        @(negedge clk);
        idle_inputs();
        ifc.A = $urandom; ifc.B = $urandom;
        model(op, a, b);
        n = 0;
        while (ifc.busy === 1'b1 && n < 50) begin
            chk("done_low_while_busy", {31'd0, ifc.done}, 32'd0);
            if (interfere && n == 1) begin
                ifc.start = 1'b1; ifc.md_op = 3'd0; ifc.A = $urandom; ifc.B = $urandom;
            end else if (interfere && n == 3) begin
                ifc.start = 1'b0; ifc.md_op = 3'd4; ifc.A = $urandom;
            end else begin
                idle_inputs();
            end
            n++;
            @(negedge clk);
        end
        idle_inputs();
        chk("busy_cycles", 32'(n), 32'(exp_n));
        chk("done_pulse", {31'd0, ifc.done}, 32'd1);
        chk("hi_commit", ifc.HI, m_hi);
        chk("lo_commit", ifc.LO, m_lo);
        @(negedge clk);
        chk("done_single", {31'd0, ifc.done}, 32'd0);
        chk("busy_after", {31'd0, ifc.busy}, 32'd0);
    endtask

    task automatic run_mt(input logic [2:0] op, input logic [31:0] a);
        @(negedge clk);
        ifc.start = 1'b0; ifc.md_op = op; ifc.A = a;
        @(negedge clk);
        idle_inputs();
        model(op, a, 32'd0);
        chk("mt_hi", ifc.HI, m_hi);
        chk("mt_lo", ifc.LO, m_lo);
        chk("mt_busy", {31'd0, ifc.busy}, 32'd0);
        chk("mt_done", {31'd0, ifc.done}, 32'd0);
    endtask

    initial begin
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        reset = 1'b1;
        idle_inputs();
        ifc.A = 32'd0; ifc.B = 32'd0;
        repeat (2) @(negedge clk);
        chk("rst_busy", {31'd0, ifc.busy}, 32'd0);
        chk("rst_done", {31'd0, ifc.done}, 32'd0);
        chk("rst_hi", ifc.HI, 32'd0);
        chk("rst_lo", ifc.LO, 32'd0);
        reset = 1'b0;

        run_md(3'd0, 32'hFFFF_FFFE, 32'd3, 1'b0);
        chk("mult_hi_const", ifc.HI, 32'hFFFF_FFFF);
        chk("mult_lo_const", ifc.LO, 32'hFFFF_FFFA);
        run_md(3'd1, 32'hFFFF_FFFF, 32'd2, 1'b0);
        chk("multu_hi_const", ifc.HI, 32'h0000_0001);
        chk("multu_lo_const", ifc.LO, 32'hFFFF_FFFE);
        run_md(3'd2, 32'hFFFF_FFF9, 32'd2, 1'b0);
        chk("div_hi_const", ifc.HI, 32'hFFFF_FFFF);
        chk("div_lo_const", ifc.LO, 32'hFFFF_FFFD);

        run_mt(3'd4, 32'h0000_0011);
        run_mt(3'd5, 32'h0000_0022);
        run_md(3'd3, 32'd7, 32'd0, 1'b0);
        chk("divu0_hi_const", ifc.HI, 32'h0000_0011);
        chk("divu0_lo_const", ifc.LO, 32'h0000_0022);

        run_md(3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
        chk("ovf_lo_const", ifc.LO, 32'h8000_0000);
        chk("ovf_hi_const", ifc.HI, 32'h0000_0000);

        run_md(3'd2, 32'd100, 32'hFFFF_FFF9, 1'b1);

        // mthi then mtlo on consecutive edges
        @(negedge clk);
        ifc.start = 1'b0; ifc.md_op = 3'd4; ifc.A = 32'h1234_5678;
        @(negedge clk);
        ifc.md_op = 3'd5; ifc.A = 32'h9ABC_DEF0;
        chk("b2b_hi", ifc.HI, 32'h1234_5678);
        chk("b2b_busy0", {31'd0, ifc.busy}, 32'd0);
        @(negedge clk);
        idle_inputs();
        chk("b2b_lo", ifc.LO, 32'h9ABC_DEF0);
        chk("b2b_hi_hold", ifc.HI, 32'h1234_5678);
        chk("b2b_busy1", {31'd0, ifc.busy}, 32'd0);
        m_hi = 32'h1234_5678; m_lo = 32'h9ABC_DEF0;

        // start with a non-launching op leaves the unit idle
        @(negedge clk);
        ifc.start = 1'b1; ifc.md_op = 3'd6; ifc.A = $urandom;
        @(negedge clk);
        idle_inputs();
        chk("nop_busy", {31'd0, ifc.busy}, 32'd0);
        chk("nop_hi", ifc.HI, m_hi);
        chk("nop_lo", ifc.LO, m_lo);

        for (int i = 0; i < 24; i++) begin
            op = 3'($urandom_range(0, 5));
            a  = $urandom;
            b  = $urandom;
            if (op[1] && $urandom_range(0, 3) == 0) b = 32'd0;
            if (op == 3'd2 && $urandom_range(0, 3) == 0) b = 32'($urandom_range(1, 9));
            if (op >= 3'd4) run_mt(op, a);
            else run_md(op, a, b, bit'($urandom_range(0, 1)));
        end

        // reset in the middle of a divide aborts it
        @(negedge clk);
        ifc.start = 1'b1; ifc.md_op = 3'd2; ifc.A = 32'd1000; ifc.B = 32'd7;
        @(negedge clk);
        idle_inputs();
        repeat (3) @(negedge clk);
        chk("mid_busy", {31'd0, ifc.busy}, 32'd1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("abort_busy", {31'd0, ifc.busy}, 32'd0);
        chk("abort_hi", ifc.HI, 32'd0);
        chk("abort_lo", ifc.LO, 32'd0);
        chk("abort_done", {31'd0, ifc.done}, 32'd0);
        for (int k = 0; k < DC; k++) begin
            @(negedge clk);
            chk("abort_no_done", {31'd0, ifc.done}, 32'd0);
        end
        chk("abort_lo_final", ifc.LO, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/mdu_hilo.md
Name: mdu_hilo

Overview:
- Multi-cycle multiply/divide responder with HI/LO registers for the E stage.
- E-stage control issues a request (start + op + operands); this block accepts it, holds busy for a fixed latency, then commits HI/LO.
- The E-stage ALU covers single-cycle ops; this block covers mult/multu/div/divu/mthi/mtlo/mfhi/mflo.
- The hazard unit stalls D-stage md-class instructions while start or busy is high.

Parameters:
- MULT_CYCLES, 5, cycles busy stays high after a multiply is accepted (≥2).
- DIV_CYCLES, 10, cycles busy stays high after a divide is accepted (≥2).

Ports:
- clk  input  1  system clock; all state changes on rising edge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  request strobe for mult/multu/div/divu (single cycle).
- md_op  input  3  0 mult, 1 multu, 2 div, 3 divu, 4 mthi, 5 mtlo, 6/7 none.
- A  input  32  operand rs (forwarded value).
- B  input  32  operand rt (forwarded value).
- busy  output  1  unit is computing; new requests are not accepted.
- done  output  1  one-cycle pulse in the cycle HI/LO commit.
- HI  output  32  HI register (mfhi read value).
- LO  output  32  LO register (mflo read value).

Behaviour:
- Reset (synchronous, active-high) takes priority over all other inputs:
  - busy=0, done=0, HI=0, LO=0, FSM→IDLE.
  - Reset during an operation aborts it; no commit occurs.
- FSM states:
  - IDLE:
    - start=1 with md_op 0..3 → latch A, B, op; load counter with MULT_CYCLES or DIV_CYCLES; go to RUN.
    - busy rises the cycle after the accepting edge.
  - RUN:
    - busy=1; counter decrements each cycle.
    - When counter reaches 1: write latched result into HI/LO at that edge, pulse done=1 for the following cycle, return to IDLE with busy=0.
- Latency:
  - busy is high for exactly MULT_CYCLES or DIV_CYCLES cycles.
  - New HI/LO are visible the cycle busy falls.
- Arithmetic:
  - Compute from latched operands only. Changes on A/B after acceptance are ignored.
  - mult: {HI,LO} = signed 64-bit product.
  - multu: {HI,LO} = unsigned 64-bit product.
  - div: LO = quotient, HI = remainder; signed, truncation toward zero, remainder takes the sign of the dividend.
  - divu: same as div, unsigned.
  - Divide by zero: HI/LO unchanged. busy/done timing is identical to a normal divide.
  - Signed overflow 0x80000000 / -1: LO=0x80000000, HI=0.
- mthi/mtlo:
  - Write A into HI or LO at the next edge; single cycle; no busy, no done.
  - Accepted only when busy=0. Request encoding is start=0 with md_op 4/5; start is ignored for these ops.
- Requests while busy: start and md_op are ignored and the latched operation continues. The upstream stall must prevent this; the block stays safe regardless.
- start with md_op 4..7 in IDLE: no operation is launched.
- HI/LO are never partially updated; both change on the same edge.
- done and busy are never high in the same cycle.

Test Plan:
- Reset then idle: assert reset 2 cycles → busy=0, done=0, HI=0, LO=0.
- mult: start, op0, A=0xFFFFFFFE (-2), B=3 → busy high 5 cycles; then HI=0xFFFFFFFF, LO=0xFFFFFFFA, done pulses once.
- multu: A=0xFFFFFFFF, B=2 → HI=0x00000001, LO=0xFFFFFFFE after 5 busy cycles.
- div: A=-7 (0xFFFFFFF9), B=2 → after 10 busy cycles LO=0xFFFFFFFD, HI=0xFFFFFFFF.
- divu: A=7, B=0 with prior HI=0x11, LO=0x22 → 10 busy cycles, done pulses, HI/LO unchanged.
- Busy interference and reset: during a div, pulse start with mult and change A/B → ignored, original div result commits. Separately assert reset mid-RUN → next cycle busy=0, HI=LO=0, no done.
- mthi then mtlo back-to-back, A=0x12345678 then 0x9ABCDEF0 → HI and LO updated on consecutive edges, busy stays 0.
